demux1x9_using_1x4demux: RTL and testbench

- Registered 1-to-9 demultiplexer that routes data input i to one of nine output lanes selected by the 4-bit s.
- Built hierarchically from 1x4 demux sub-blocks in a two-level tree. A first-stage 1x4 decodes s[3:2]; second-stage 1x4s decode s[1:0].
- Used as a generic fan-out steering element in datapath and control logic.
- Outputs are registered, giving one cycle of latency.

---
 rtl/demux1x9_using_1x4demux_if.sv | 41 ++++
 rtl/demux1x9_using_1x4demux.sv | 147 ++++++++++++++
 tb/tb_demux1x9_using_1x4demux.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/demux1x9_using_1x4demux_if.sv
// ---------------------------------------------------------------------------
// demux1x9_using_1x4demux_if
//
// Bundles the data/select inputs and the registered lane outputs of the
// 1-to-9 demultiplexer so the block can be connected as a single port.
//
// Parameters:
//   DW       data width of i and of each output lane
//
// Signals:
//   i        [DW-1:0]    data to be routed
//   s        [3:0]       lane select, valid range 0..8
//   y        [9*DW-1:0]  output lanes, lane k = y[k*DW +: DW]
//   sel_err  1           registered out-of-range select flag
//
// Modports:
//   master   drives i/s, observes y/sel_err (the user of the demux)
//   slave    receives i/s, drives y/sel_err (the demux itself)
// ---------------------------------------------------------------------------
interface demux1x9_using_1x4demux_if #(
  parameter int DW = 1
);
  logic [DW-1:0]   i;
  logic [3:0]      s;
  logic [9*DW-1:0] y;
  logic            sel_err;

  modport master (
    output i,
    output s,
    input  y,
    input  sel_err
  );

  modport slave (
    input  i,
    input  s,
    output y,
    output sel_err
  );
endinterface

// File: rtl/demux1x9_using_1x4demux.sv
// ---------------------------------------------------------------------------
// demux1x9_using_1x4demux
//
// Registered 1-to-9 demultiplexer built as a two-level tree of 1x4 demux
// sub-blocks. The first stage decodes s[3:2] into a branch, the second
// stage decodes s[1:0] into a lane inside that branch:
//   branch 0 -> lanes 0..3
//   branch 1 -> lanes 4..7
//   branch 2 -> lane 8 only (its outputs 1..3 are never built)
//   branch 3 -> dropped
// The tree is purely combinational; a single register stage gives exactly
// one cycle of latency from i/s to y. Any select in 9..15 lands on a dropped
// branch output, so every lane is zero for it.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, clears y and sel_err
//   bus   demux1x9_using_1x4demux_if.slave (i, s in; y, sel_err out)
//
// Build option:
//   DEMUX_SEL_ERR_EN  when defined, sel_err is a registered flag that is 1
//                     on the cycle after an out-of-range select (s > 8).
//                     When undefined, sel_err is tied to 0. The port exists
//                     in both builds and the routing of y is identical.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// demux1x9_using_1x4demux_demux1x4
//
// Combinational 1x4 demux: output j = i when s == j, else 0.
// NOUT selects how many of the four outputs are actually produced; an
// output the parent would discard is simply not generated, which keeps
// the parent free of dangling nets.
//
// Parameters:
//   DW    data width
//   NOUT  number of outputs produced (1..4), outputs 0..NOUT-1
//
// Ports:
//   i     [DW-1:0]       data in
//   s     [1:0]          select
//   y     [NOUT*DW-1:0]  outputs, output j = y[j*DW +: DW]
// ---------------------------------------------------------------------------
module demux1x9_using_1x4demux_demux1x4 #(
  parameter int DW   = 1,
  parameter int NOUT = 4
) (
  input  logic [DW-1:0]      i,
  input  logic [1:0]         s,
  output logic [NOUT*DW-1:0] y
);

  generate
    for (genvar gi = 0; gi < NOUT; gi++) begin : g_out
      assign y[gi*DW +: DW] = (s == 2'(gi)) ? i : '0;
    end
  endgenerate

endmodule

module demux1x9_using_1x4demux #(
  parameter int DW = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  demux1x9_using_1x4demux_if.slave    bus
);

  localparam int NLANE   = 9;
  localparam int NBRANCH = 3;  // branches that feed at least one lane

  // -------------------------------------------------------------------------
  // Combinational front end
  // -------------------------------------------------------------------------
  // First-stage outputs for branches 0..2; branch 3 is not generated.
  logic [NBRANCH*DW-1:0] stage1_y;
  // Flattened lane vector straight out of the tree.
  logic [NLANE*DW-1:0]   tree_y;

  demux1x9_using_1x4demux_demux1x4 #(
    .DW   (DW),
    .NOUT (NBRANCH)
  ) u_stage1 (
    .i (bus.i),
    .s (bus.s[3:2]),
    .y (stage1_y)
  );

  // Branches 0 and 1 produce four lanes each; branch 2 only produces lane 8.
  generate
    for (genvar gi = 0; gi < NBRANCH; gi++) begin : g_branch
      localparam int BR_NOUT = (gi == NBRANCH - 1) ? 1 : 4;

      demux1x9_using_1x4demux_demux1x4 #(
        .DW   (DW),
        .NOUT (BR_NOUT)
      ) u_stage2 (
        .i (stage1_y[gi*DW +: DW]),
        .s (bus.s[1:0]),
        .y (tree_y[gi*4*DW +: BR_NOUT*DW])
      );
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Register stage
  // -------------------------------------------------------------------------
  logic [NLANE*DW-1:0] y_reg;
  logic [NLANE*DW-1:0] y_next;

  assign y_next = tree_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg <= '0;
    end else begin
      y_reg <= y_next;
    end
  end

  assign bus.y = y_reg;

  // -------------------------------------------------------------------------
  // Out-of-range select flag
  // -------------------------------------------------------------------------
`ifdef DEMUX_SEL_ERR_EN
  logic sel_err_reg;
  logic sel_err_next;

  // Registered alongside y so the flag lines up with the all-zero lanes
  // produced by the same select.
  assign sel_err_next = (bus.s > 4'd8);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_reg <= 1'b0;
    end else begin
      sel_err_reg <= sel_err_next;
    end
  end

  assign bus.sel_err = sel_err_reg;
`else
  assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux1x9_using_1x4demux.sv
// ---------------------------------------------------------------------------
// tb_demux1x9_using_1x4demux
//
// Self-checking bench for the registered 1-to-9 demux (DW = 1). Each
// transaction drives rst/i/s on the falling edge, pushes its expected
// y/sel_err onto a scoreboard queue, and pops/compares 1 ns after the
// following rising edge. A directed vector table covers reset, the valid
// sweep, invalid selects and zero data; hand-written sequences cover the
// random stress and the mid-stream reset. Build with +define+DEMUX_SEL_ERR_EN
// to check the sel_err flag as well.
// ---------------------------------------------------------------------------
module tb_demux1x9_using_1x4demux;

`ifdef DEMUX_SEL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int DW    = 1;
  localparam int NVEC  = 22;

  logic clk;
  logic rst;

  demux1x9_using_1x4demux_if #(.DW(DW)) bus ();

  demux1x9_using_1x4demux #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       i;
    logic [3:0] s;
    logic [8:0] y;
    logic       oor;   // select out of range
  } vec_t;

  typedef struct {
    logic [8:0] y;
    logic       err;
    string      tag;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb [$];

  int total = 0;
  int bad   = 0;

  task automatic check_one();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got y=%03h, required a queued expectation", bus.y);
      return;
    end
    e = sb.pop_front();
    if (bus.y !== e.y) begin
      bad++;
      $display("FAIL %s y: got %03h, required %03h", e.tag, bus.y, e.y);
    end
    total++;
    if (bus.sel_err !== e.err) begin
      bad++;
      $display("FAIL %s sel_err: got %0b, required %0b", e.tag, bus.sel_err, e.err);
    end
    total++;
    if ($countones(bus.y) > 1) begin
      bad++;
      $display("FAIL %s onehot: got popcount %0d, required <= 1", e.tag, $countones(bus.y));
    end
    $display("txn %-8s y=%03h sel_err=%0b exp_y=%03h exp_err=%0b",
             e.tag, bus.y, bus.sel_err, e.y, e.err);
  endtask

  task automatic apply(input logic r, input logic d, input logic [3:0] sel,
                       input logic [8:0] ey, input logic eoor, input string tag);
    exp_t e;
    @(negedge clk);
    rst   = r;
    bus.i = d;
    bus.s = sel;
    e.y   = ey;
    e.err = ERR_EN ? eoor : 1'b0;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_one();
  endtask

  // Bound on the whole run so a stuck clock or wait can never hang the bench.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rs;
    logic [8:0] ry;

    // reset: two cycles held, then release on s=3
    vecs[0]  = '{1'b1, 1'b1, 4'd3,  9'h000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 4'd3,  9'h000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'd3,  9'h008, 1'b0};
    // valid sweep
    vecs[3]  = '{1'b0, 1'b1, 4'd0,  9'h001, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'd1,  9'h002, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'd2,  9'h004, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 4'd3,  9'h008, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'd4,  9'h010, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'd5,  9'h020, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'd6,  9'h040, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'd7,  9'h080, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 4'd8,  9'h100, 1'b0};
    // invalid selects
    vecs[12] = '{1'b0, 1'b1, 4'd9,  9'h000, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 4'd10, 9'h000, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 4'd11, 9'h000, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 4'd12, 9'h000, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 4'd13, 9'h000, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 4'd14, 9'h000, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 4'd15, 9'h000, 1'b1};
    // back to a valid lane right after an invalid run, then zero data
    vecs[19] = '{1'b0, 1'b1, 4'd0,  9'h001, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 4'd5,  9'h000, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 4'd5,  9'h020, 1'b0};

    rst   = 1'b1;
    bus.i = '0;
    bus.s = '0;

    for (int k = 0; k < NVEC; k++) begin
      apply(vecs[k].rst, vecs[k].i, vecs[k].s, vecs[k].y, vecs[k].oor, $sformatf("vec%0d", k));
    end

    // random stress: expected lane from the select driven that cycle
    for (int n = 0; n < 10; n++) begin
      rs = 4'($urandom_range(0, 15));
      ry = (rs <= 4'd8) ? (9'h001 << rs) : 9'h000;
      apply(1'b0, 1'b1, rs, ry, (rs > 4'd8), $sformatf("rand%0d", n));
    end

    // reset mid-stream on lane 8
    apply(1'b0, 1'b1, 4'd8, 9'h100, 1'b0, "mid_run");
    apply(1'b1, 1'b1, 4'd8, 9'h000, 1'b0, "mid_rst");
    apply(1'b0, 1'b1, 4'd8, 9'h100, 1'b0, "mid_rel");

    // reset must also clear a pending sel_err
    apply(1'b0, 1'b1, 4'd15, 9'h000, 1'b1, "err_set");
    apply(1'b1, 1'b1, 4'd15, 9'h000, 1'b0, "err_rst");

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover, required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
